// File: rtl/io_fifo_interface_if.sv
// CPU register bus plus UART byte streams for io_fifo_interface.
// The master modport is the CPU/UART side; the slave modport is the FIFO block.
interface io_fifo_interface_if;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic [3:0]  WrEn;
    logic        RdEn;
    logic [31:0] RData;
    logic        Irq;
    logic [7:0]  TxData;
    logic        TxValid;
    logic        TxReady;
    logic [7:0]  RxData;
    logic        RxValid;
    logic        RxReady;

    modport master (
        output Addr, WData, WrEn, RdEn, TxReady, RxData, RxValid,
        input  RData, Irq, TxData, TxValid, RxReady
    );

    modport slave (
        input  Addr, WData, WrEn, RdEn, TxReady, RxData, RxValid,
        output RData, Irq, TxData, TxValid, RxReady
    );
endinterface

// File: rtl/io_fifo_interface.sv
// Memory-mapped UART FIFO block: an RX and a TX byte FIFO behind four CPU
// registers (STATUS, RXDATA, TXDATA, CTRL), with sticky overflow flags and a
// level interrupt.
module io_fifo_interface #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input logic             Clock,
    input logic             Reset,
    io_fifo_interface_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [31:0] STATUS_ADDR = BASE_ADDR;
    localparam logic [31:0] RXDATA_ADDR = BASE_ADDR + 32'h4;
    localparam logic [31:0] TXDATA_ADDR = BASE_ADDR + 32'h8;
    localparam logic [31:0] CTRL_ADDR   = BASE_ADDR + 32'hC;

    // Count update shared by both FIFOs; push+pop together leaves it unchanged.
    function automatic logic [CW-1:0] next_count(input logic [CW-1:0] cnt,
                                                 input logic push, input logic pop);
        logic [CW-1:0] res;
        res = cnt;
        if (push && !pop)
            res = cnt + CW'(1);
        else if (pop && !push)
            res = cnt - CW'(1);
        return res;
    endfunction

    // Counts sit in 8-bit STATUS fields; wider counts are truncated.
    function automatic logic [7:0] count_field(input logic [CW-1:0] cnt);
        logic [31:0] wide;
        wide = 32'(cnt);
        return wide[7:0];
    endfunction

    logic [7:0]    rx_mem [DEPTH];
    logic [7:0]    tx_mem [DEPTH];
    logic [PW-1:0] rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;
    logic [CW-1:0] rx_count, tx_count;
    logic          rx_overflow, tx_overflow;
    logic          irq_rx_en, irq_tx_en;
    logic [31:0]   rd_mux;

    logic hit_status, hit_rxdata, hit_txdata, hit_ctrl;
    logic tx_wr, ctrl_wr, flush_rx, flush_tx, clr_ovf;
    logic rx_empty, rx_full, tx_empty, tx_full;
    logic rx_push, rx_pop, rx_drop, tx_push, tx_pop, tx_drop;
    logic unused_bits;

    assign hit_status = (bus.Addr == STATUS_ADDR);
    assign hit_rxdata = (bus.Addr == RXDATA_ADDR);
    assign hit_txdata = (bus.Addr == TXDATA_ADDR);
    assign hit_ctrl   = (bus.Addr == CTRL_ADDR);

    assign tx_wr    = bus.WrEn[0] & hit_txdata;
    assign ctrl_wr  = bus.WrEn[0] & hit_ctrl;
    assign flush_rx = ctrl_wr & bus.WData[0];
    assign flush_tx = ctrl_wr & bus.WData[1];
    assign clr_ovf  = ctrl_wr & bus.WData[2];

    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == FULL_CNT);
    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == FULL_CNT);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
    assign rx_pop  = bus.RdEn & hit_rxdata & ~rx_empty;
    assign rx_push = bus.RxValid & (~rx_full | rx_pop);
    assign rx_drop = bus.RxValid & rx_full & ~rx_pop & ~flush_rx;
    assign tx_pop  = bus.TxReady & ~tx_empty;
    assign tx_push = tx_wr & (~tx_full | tx_pop);
    assign tx_drop = tx_wr & tx_full & ~tx_pop & ~flush_tx;

    assign bus.TxValid = ~tx_empty;
    assign bus.TxData  = tx_mem[tx_rd_ptr];
    assign bus.RxReady = 1'b1;
    assign bus.Irq     = (irq_rx_en & ~rx_empty) | (irq_tx_en & tx_empty);

    assign unused_bits = ^{bus.WrEn[3:1], bus.WData[31:8]};

    // RX pointers and count; a flush overrides any same-cycle push or pop.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else if (flush_rx) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push)
                rx_wr_ptr <= rx_wr_ptr + PW'(1);
            if (rx_pop)
                rx_rd_ptr <= rx_rd_ptr + PW'(1);
            rx_count <= next_count(rx_count, rx_push, rx_pop);
        end
    end

    // TX pointers and count; a flush overrides any same-cycle push or pop.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else if (flush_tx) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push)
                tx_wr_ptr <= tx_wr_ptr + PW'(1);
            if (tx_pop)
                tx_rd_ptr <= tx_rd_ptr + PW'(1);
            tx_count <= next_count(tx_count, tx_push, tx_pop);
        end
    end

    // FIFO storage is data only; stale entries are unreachable once pointers reset.
    always_ff @(posedge Clock) begin
        if (rx_push && !flush_rx)
            rx_mem[rx_wr_ptr] <= bus.RxData;
        if (tx_push && !flush_tx)
            tx_mem[tx_wr_ptr] <= bus.WData[7:0];
    end

    // Sticky overflow flags (a same-cycle set beats the clear) and IRQ enables.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rx_overflow <= 1'b0;
            tx_overflow <= 1'b0;
            irq_rx_en   <= 1'b0;
            irq_tx_en   <= 1'b0;
        end else begin
            if (rx_drop)
                rx_overflow <= 1'b1;
            else if (clr_ovf)
                rx_overflow <= 1'b0;
            if (tx_drop)
                tx_overflow <= 1'b1;
            else if (clr_ovf)
                tx_overflow <= 1'b0;
            if (ctrl_wr) begin
                irq_rx_en <= bus.WData[3];
                irq_tx_en <= bus.WData[4];
            end
        end
    end

    // Read data selection from current registered state.
    always_comb begin
        rd_mux = '0;
        if (hit_status)
            rd_mux = {8'h00, count_field(tx_count), count_field(rx_count),
                      3'b000, tx_overflow, tx_empty, rx_overflow, ~rx_empty, ~tx_full};
        else if (hit_rxdata && !rx_empty)
            rd_mux = {24'h0, rx_mem[rx_rd_ptr]};
        else if (hit_ctrl)
            rd_mux = {27'h0, irq_tx_en, irq_rx_en, 3'b000};
    end

    // Registered read port; holds its value between reads.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            bus.RData <= '0;
        else if (bus.RdEn)
            bus.RData <= rd_mux;
    end
endmodule

// File: tb/tb_io_fifo_interface.sv
// Scoreboard bench for io_fifo_interface: directed register and UART traffic,
// expected read data and TX bytes queued at issue time, checked by a monitor.
module tb_io_fifo_interface;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] A_ST = BASE;
    localparam logic [31:0] A_RX = BASE + 32'h4;
    localparam logic [31:0] A_TX = BASE + 32'h8;
    localparam logic [31:0] A_CT = BASE + 32'hC;

    logic Clock;
    logic Reset;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [31:0] rd_q[$];
    string       rd_name_q[$];
    logic [7:0]  tx_q[$];
    logic        rd_pend = 1'b0;

    io_fifo_interface_if bus();

    io_fifo_interface #(.DEPTH(8), .BASE_ADDR(BASE)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: inputs are stable at the falling edge; read data is checked one
    // cycle after the read strobe, TX bytes on every accepted handshake.
    always @(negedge Clock) begin
        if (rd_pend) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rdata: unexpected read, got 0x%08h expected none", bus.RData);
            end else begin
                check(rd_name_q.pop_front(), bus.RData, rd_q.pop_front());
            end
        end
        rd_pend = bus.RdEn && Reset;
        if (bus.TxValid && bus.TxReady && Reset) begin
            if (tx_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL txdata: unexpected byte 0x%02h expected none", bus.TxData);
            end else begin
                check("txdata", {24'h0, bus.TxData}, {24'h0, tx_q.pop_front()});
            end
        end
    end

    task automatic cycle();
        @(posedge Clock);
        #2;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        bus.Addr  = a;
        bus.RdEn  = 1'b1;
        rd_q.push_back(exp);
        rd_name_q.push_back(name);
        cycle();
        bus.RdEn  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.Addr  = a;
        bus.WData = d;
        bus.WrEn  = 4'h1;
        cycle();
        bus.WrEn  = 4'h0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        bus.RxData  = b;
        bus.RxValid = 1'b1;
        cycle();
        bus.RxValid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset       = 1'b0;
        bus.Addr    = '0;
        bus.WData   = '0;
        bus.WrEn    = '0;
        bus.RdEn    = 1'b0;
        bus.TxReady = 1'b0;
        bus.RxData  = '0;
        bus.RxValid = 1'b0;
        cycle();
        check("reset_rdata", bus.RData, 32'h0);
        check("reset_txvalid", {31'h0, bus.TxValid}, 32'h0);
        check("reset_irq", {31'h0, bus.Irq}, 32'h0);
        check("reset_rxready", {31'h0, bus.RxReady}, 32'h1);
        cycle();
        Reset = 1'b1;
        cycle();

        rd(A_ST, 32'h0000_0009, "status_post_reset");

        // Fill TX past full while the transmitter stalls.
        for (int i = 0; i < 9; i++)
            wr(A_TX, 32'h41 + i);
        rd(A_ST, 32'h0008_0010, "status_tx_full_ovf");
        check("txvalid_full", {31'h0, bus.TxValid}, 32'h1);
        for (int i = 0; i < 8; i++)
            tx_q.push_back(8'(8'h41 + i));
        bus.TxReady = 1'b1;
        for (int i = 0; i < 8; i++)
            cycle();
        check("txvalid_drained", {31'h0, bus.TxValid}, 32'h0);
        rd(A_ST, 32'h0000_0019, "status_tx_empty_ovf");
        wr(A_CT, 32'h04);
        rd(A_ST, 32'h0000_0009, "status_ovf_cleared");
        bus.TxReady = 1'b0;

        // Two received bytes, read back, then an empty read.
        rx_byte(8'hA5);
        rx_byte(8'h5A);
        rd(A_ST, 32'h0000_020B, "status_rx2");
        rd(A_RX, 32'h0000_00A5, "rxdata_1");
        rd(A_RX, 32'h0000_005A, "rxdata_2");
        rd(A_RX, 32'h0000_0000, "rxdata_empty");
        rd(A_ST, 32'h0000_0009, "status_rx_empty");

        // RX full: simultaneous push and pop, then a dropped byte.
        for (int i = 0; i < 8; i++)
            rx_byte(8'(8'h10 + i));
        rd(A_ST, 32'h0000_080B, "status_rx_full");
        bus.Addr    = A_RX;
        bus.RdEn    = 1'b1;
        bus.RxData  = 8'h18;
        bus.RxValid = 1'b1;
        rd_q.push_back(32'h10);
        rd_name_q.push_back("rxdata_push_pop");
        cycle();
        bus.RdEn    = 1'b0;
        bus.RxValid = 1'b0;
        rd(A_ST, 32'h0000_080B, "status_full_no_ovf");
        rx_byte(8'h19);
        rd(A_ST, 32'h0000_080F, "status_rx_ovf");
        for (int i = 0; i < 8; i++)
            rd(A_RX, 32'h11 + i, "rxdata_drain");
        rd(A_RX, 32'h0, "rxdata_after_drain");
        rd(A_ST, 32'h0000_000D, "status_ovf_sticky");
        wr(A_CT, 32'h04);
        rd(A_ST, 32'h0000_0009, "status_ovf_clear2");

        // Interrupt enables.
        wr(A_CT, 32'h08);
        rd(A_CT, 32'h0000_0008, "ctrl_readback");
        check("irq_rx_idle", {31'h0, bus.Irq}, 32'h0);
        rx_byte(8'h77);
        check("irq_rx_set", {31'h0, bus.Irq}, 32'h1);
        wr(A_CT, 32'h09);
        check("irq_after_flush", {31'h0, bus.Irq}, 32'h0);
        rd(A_ST, 32'h0000_0009, "status_rx_flushed");
        rd(A_CT, 32'h0000_0008, "ctrl_after_flush");
        wr(A_CT, 32'h10);
        check("irq_tx_empty", {31'h0, bus.Irq}, 32'h1);
        wr(A_CT, 32'h00);
        check("irq_disabled", {31'h0, bus.Irq}, 32'h0);

        // Unmapped/TXDATA reads return 0; read and write in one cycle; TX flush.
        rd(BASE + 32'h10, 32'h0, "unmapped_read");
        bus.Addr  = A_TX;
        bus.WData = 32'h55;
        bus.WrEn  = 4'h1;
        bus.RdEn  = 1'b1;
        rd_q.push_back(32'h0);
        rd_name_q.push_back("txdata_read_write");
        cycle();
        bus.WrEn  = 4'h0;
        bus.RdEn  = 1'b0;
        rd(A_ST, 32'h0001_0001, "status_tx1");
        wr(A_CT, 32'h02);
        rd(A_ST, 32'h0000_0009, "status_tx_flushed");

        // Reset in the middle of traffic.
        for (int i = 0; i < 5; i++)
            wr(A_TX, 32'h61 + i);
        check("txvalid_5", {31'h0, bus.TxValid}, 32'h1);
        check("txdata_head", {24'h0, bus.TxData}, 32'h61);
        rd(A_ST, 32'h0005_0001, "status_tx5");
        cycle();
        Reset = 1'b0;
        #1;
        check("midreset_txvalid", {31'h0, bus.TxValid}, 32'h0);
        check("midreset_irq", {31'h0, bus.Irq}, 32'h0);
        check("midreset_rdata", bus.RData, 32'h0);
        check("midreset_rxready", {31'h0, bus.RxReady}, 32'h1);
        cycle();
        Reset = 1'b1;
        cycle();
        rd(A_ST, 32'h0000_0009, "status_after_reset");
        cycle();
        cycle();
        check("scoreboard_empty", 32'(rd_q.size() + tx_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/io_fifo_interface.md
IO_FIFO_INTERFACE -- requirements
Module: io_fifo_interface

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the entries per FIFO (power of two, 2..256); CW = log2(DEPTH)+1 is the count width.
REQ-002 Parameter BASE_ADDR, default 32'h80000000, SHALL set the register block base: STATUS +0x0, RXDATA +0x4, TXDATA +0x8, CTRL +0xC.
REQ-003 Clock  in  1  sole clock; all state changes on the rising edge.
REQ-004 Reset  in  1  asynchronous, active-low reset.
REQ-005 Addr  in  32  CPU word address; exact match only.
REQ-006 WData  in  32  CPU write data.
REQ-007 WrEn  in  4  byte write enables; only WrEn[0] qualifies a write.
REQ-008 RdEn  in  1  CPU read strobe.
REQ-009 RData  out  32  registered read data.
REQ-010 Irq  out  1  level interrupt.
REQ-011 TxData  out  8  byte to the UART transmitter.
REQ-012 TxValid  out  1  TX FIFO non-empty.
REQ-013 TxReady  in  1  UART accepts TxData.
REQ-014 RxData  in  8  byte from the UART receiver.
REQ-015 RxValid  in  1  RxData valid.
REQ-016 RxReady  out  1  tied to 1; the block never back-pressures the receiver.

Function
REQ-017 Two circular FIFOs (RX, TX) of DEPTH x 8 SHALL use read/write pointers wrapping modulo DEPTH and a CW-bit count (0..DEPTH).
REQ-018 A read (RdEn=1) SHALL update RData at the next rising edge; RData SHALL hold its value when RdEn=0; a read of an unmapped address or of TXDATA SHALL return 0.
REQ-019 STATUS read SHALL return: bit0 tx_not_full, bit1 rx_not_empty, bit2 rx_overflow, bit3 tx_empty, bit4 tx_overflow, [15:8] rx_count, [23:16] tx_count, all other bits 0 (counts zero-extended).
REQ-020 RXDATA read SHALL return {24'b0, RX head} and pop one entry when RX is non-empty; when RX is empty, it SHALL return 0 and leave the FIFO unchanged.
REQ-021 TXDATA write (WrEn[0]=1) SHALL push WData[7:0] when TX is not full; when TX is full, the byte SHALL be dropped and tx_overflow set.
REQ-022 RX push SHALL occur on RxValid=1 when RX is not full; when RX is full and no pop occurs in the same cycle, the byte SHALL be dropped and rx_overflow set.
REQ-023 Simultaneous push and pop on the same FIFO SHALL both take effect with the count unchanged, including when full; when the FIFO is empty, only the push takes effect.
REQ-024 TxValid SHALL equal tx_count!=0; TxData SHALL equal the TX head; a TX pop SHALL occur when TxValid and TxReady are both 1.
REQ-025 CTRL write bits:
- bit0: flush RX (self-clearing).
- bit1: flush TX (self-clearing).
- bit2: clear both sticky overflow flags (self-clearing).
- bit3: irq_rx_en (stored).
- bit4: irq_tx_en (stored).
REQ-026 CTRL read SHALL return {27'b0, irq_tx_en, irq_rx_en, 3'b0}.
REQ-027 Flush SHALL take priority over a same-cycle push or pop on that FIFO: pointers and count go to 0, and the incoming byte is discarded.
REQ-028 An overflow event in the same cycle as a CTRL clear SHALL leave the flag set (set wins).
REQ-029 Irq SHALL equal (irq_rx_en & rx_not_empty) | (irq_tx_en & tx_empty), decoded from registered state only.
REQ-030 A read and a write in the same cycle SHALL both execute; CTRL written in cycle N SHALL be reflected by a read issued in cycle N+1.

Reset
REQ-031 Reset=0 SHALL immediately clear: all pointers and counts, both overflow flags, both irq enables, and RData (to 0).
REQ-032 During reset, TxValid and Irq SHALL be 0 and RxReady SHALL be 1.
REQ-033 Reset asserted mid-operation SHALL discard all FIFO contents; the first edge after release SHALL behave as after power-up.

Verification
REQ-034 Post-reset STATUS read -> RData=32'h00000009 (tx_not_full, tx_empty).
REQ-035 With TxReady=0, 9 TXDATA writes 0x41..0x49 (DEPTH=8) -> tx_count=8, STATUS bit4=1; then TxReady=1 -> TxData emitted 0x41..0x48 in order, and TxValid falls after 8 pops.
REQ-036 Receive 0xA5 then 0x5A; read RXDATA twice, then a third time -> 0xA5, 0x5A, then 0 with rx_count staying 0.
REQ-037 Fill RX to 8 entries, then assert RxValid on the same cycle as an RXDATA read -> count stays 8, rx_overflow=0; a 9th byte with no read -> rx_overflow=1 and the byte is lost.
REQ-038 Write CTRL=0x08, then receive one byte -> Irq=1 one cycle after the push; write CTRL=0x09 -> RX flushed and Irq=0.
REQ-039 Assert Reset=0 while TX holds 5 bytes and TxValid=1 -> TxValid=0 immediately; after release, STATUS=32'h00000009.
